// File: rtl/fsu_linear_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fsu_linear_ctrl
// Desc   : Frame sequencer for a folded linear layer: optional weight load,
//          partitioned bitstream run, adder-tree drain, double-buffered result.
//          Optional stall counter output: define FSU_LINEAR_CTRL_STALL_CNT_EN.
// Rev    : 1.0
// ============================================================================
module fsu_linear_ctrl #(
    parameter int FOLD = 1,
    parameter int CWID = 10,
    parameter int PWID = ($clog2(FOLD) < 2) ? 1 : $clog2(FOLD),
    parameter int LAT  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iValid,
    input  logic            iWLoad,
    output logic            iReady,
    output logic            oLoad,
    output logic [PWID-1:0] oPart,
    output logic            oClear,
    output logic            oSel,
    output logic            oValid,
    input  logic            oReady
`ifdef FSU_LINEAR_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]     oStall
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [PWID-1:0] c_last_part  = PWID'(FOLD - 1);
    // Only reachable when LAT > 0, so the LAT = 0 wrap value is never compared.
    localparam logic [3:0]      c_last_drain = 4'(LAT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [CWID-1:0]   r_cnt;
    logic [PWID-1:0]   r_part;
    logic [3:0]        r_drain;
    logic              r_sel;
    logic              w_cnt_last;
    logic              w_part_last;

    assign w_cnt_last  = &r_cnt;
    assign w_part_last = (r_part == c_last_part);

    always_comb begin
        w_next_state = r_state;
        iReady       = 1'b0;
        oLoad        = 1'b0;
        oClear       = 1'b0;
        oValid       = 1'b0;
        oPart        = r_part;
        oSel         = r_sel;
        case (r_state)
            IDLE: begin
                iReady = 1'b1;
                if (iValid)
                    w_next_state = iWLoad ? LOAD : RUN;
            end
            LOAD: begin
                oLoad        = 1'b1;
                w_next_state = RUN;
            end
            RUN: begin
                oClear = (r_cnt == '0) && (r_part == '0);
                if (w_cnt_last && w_part_last)
                    w_next_state = (LAT > 0) ? DRAIN : DONE;
            end
            DRAIN: begin
                // Keep the mux pointed at the last partition while the tree flushes.
                oPart = c_last_part;
                if (r_drain == c_last_drain)
                    w_next_state = DONE;
            end
            DONE: begin
                oValid = 1'b1;
                if (oReady)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_part  <= '0;
            r_drain <= '0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == RUN) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_cnt_last)
                    r_part <= w_part_last ? '0 : r_part + 1'b1;
            end
            if (r_state == DRAIN)
                r_drain <= r_drain + 1'b1;
            else
                r_drain <= '0;
            if ((r_state == DONE) && oReady)
                r_sel <= ~r_sel;
        end
    end

`ifdef FSU_LINEAR_CTRL_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall <= '0;
        else if ((r_state == DONE) && !oReady && (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;
    end

    assign oStall = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsu_linear_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_fsu_linear_ctrl
// Desc   : Self-checking bench: two configurations driven in lock-step against
//          a frame-timeline reference model, plus directed tables/sequences.
// Rev    : 1.0
// ============================================================================
module tb_fsu_linear_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, iValid, iWLoad, oReady;
    logic iReady0, oLoad0, oClear0, oSel0, oValid0;
    logic iReady1, oLoad1, oClear1, oSel1, oValid1;
    logic [0:0] oPart0, oPart1;
`ifdef FSU_LINEAR_CTRL_STALL_CNT_EN
    logic [15:0] oStall0, oStall1;
`endif

    fsu_linear_ctrl #(.FOLD(2), .CWID(3), .LAT(2)) u_dut0 (
        .clk(clk), .rst(rst), .iValid(iValid), .iWLoad(iWLoad), .iReady(iReady0),
        .oLoad(oLoad0), .oPart(oPart0), .oClear(oClear0), .oSel(oSel0),
        .oValid(oValid0), .oReady(oReady)
`ifdef FSU_LINEAR_CTRL_STALL_CNT_EN
        , .oStall(oStall0)
`endif
    );

    fsu_linear_ctrl #(.FOLD(1), .CWID(2), .LAT(0)) u_dut1 (
        .clk(clk), .rst(rst), .iValid(iValid), .iWLoad(iWLoad), .iReady(iReady1),
        .oLoad(oLoad1), .oPart(oPart1), .oClear(oClear1), .oSel(oSel1),
        .oValid(oValid1), .oReady(oReady)
`ifdef FSU_LINEAR_CTRL_STALL_CNT_EN
        , .oStall(oStall1)
`endif
    );

    typedef struct packed {
        logic       irdy;
        logic       load;
        logic [3:0] part;
        logic       clr;
        logic       sel;
        logic       vld;
    } out_t;

    typedef struct packed {
        logic v;
        logic wl;
        logic rdy;
        out_t exp;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // Timeline model: a frame is "cycles since acceptance"; outputs follow arithmetically.
    bit m_busy  [2] = '{0, 0};
    int m_k     [2] = '{0, 0};
    bit m_load  [2] = '{0, 0};
    bit m_sel   [2] = '{0, 0};
    int m_stall [2] = '{0, 0};

    function automatic out_t model_out(input int d);
        int   f, c, l, n, r;
        out_t o;
        f = (d == 0) ? 2 : 1;
        c = (d == 0) ? 3 : 2;
        l = (d == 0) ? 2 : 0;
        n = f * (1 << c);
        o = '0;
        o.sel = m_sel[d];
        if (!m_busy[d]) begin
            o.irdy = 1'b1;
            return o;
        end
        r = m_k[d] - (m_load[d] ? 1 : 0);
        if (r == 0)
            o.load = 1'b1;
        else if (r <= n) begin
            o.part = 4'((r - 1) >> c);
            o.clr  = (r == 1);
        end else if (r <= n + l)
            o.part = 4'(f - 1);
        else
            o.vld = 1'b1;
        return o;
    endfunction

    task automatic model_step(input int d, input logic r, v, wl, rdy);
        out_t o;
        o = model_out(d);
        if (r) begin
            m_busy[d] = 0; m_k[d] = 0; m_sel[d] = 0; m_stall[d] = 0;
        end else if (!m_busy[d]) begin
            if (v) begin
                m_busy[d] = 1; m_k[d] = 1; m_load[d] = wl;
            end
        end else if (o.vld && rdy) begin
            m_busy[d] = 0;
            m_sel[d]  = ~m_sel[d];
        end else begin
            if (o.vld && m_stall[d] < 65535)
                m_stall[d]++;
            m_k[d]++;
        end
    endtask

    function automatic out_t dut_out(input int d);
        out_t o;
        if (d == 0)
            o = '{irdy: iReady0, load: oLoad0, part: 4'(oPart0), clr: oClear0, sel: oSel0, vld: oValid0};
        else
            o = '{irdy: iReady1, load: oLoad1, part: 4'(oPart1), clr: oClear1, sel: oSel1, vld: oValid1};
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Called at a negedge: compare this cycle's outputs, then drive this cycle's inputs.
    task automatic tick(input logic r, v, wl, rdy);
        check("dut0 outputs vs model", 32'(dut_out(0)), 32'(model_out(0)));
        check("dut1 outputs vs model", 32'(dut_out(1)), 32'(model_out(1)));
`ifdef FSU_LINEAR_CTRL_STALL_CNT_EN
        check("dut0 stall vs model", 32'(oStall0), 32'(m_stall[0]));
        check("dut1 stall vs model", 32'(oStall1), 32'(m_stall[1]));
`endif
        rst = r; iValid = v; iWLoad = wl; oReady = rdy;
        @(posedge clk);
        model_step(0, r, v, wl, rdy);
        model_step(1, r, v, wl, rdy);
        @(negedge clk);
    endtask

    vec_t tbl [23];
    int   vcnt;

    initial begin
        rst = 1'b1; iValid = 1'b0; iWLoad = 1'b0; oReady = 1'b0;

        // Load-frame table for FOLD=2, CWID=3, LAT=2 (cycle 0 = acceptance).
        for (int i = 0; i < 23; i++) tbl[i] = '0;
        tbl[0].v = 1'b1; tbl[0].wl = 1'b1; tbl[0].exp.irdy = 1'b1;
        tbl[1].v = 1'b1; tbl[1].rdy = 1'b1; tbl[1].exp.load = 1'b1;
        for (int i = 2; i <= 19; i++) tbl[i].exp.part = (i >= 10) ? 4'd1 : 4'd0;
        tbl[2].exp.clr = 1'b1;
        tbl[20].exp.vld = 1'b1;
        tbl[21].exp.vld = 1'b1; tbl[21].rdy = 1'b1;
        tbl[22].exp.irdy = 1'b1; tbl[22].exp.sel = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);

        check("reset iReady",  32'(iReady0), 32'd1);
        check("reset oLoad",   32'(oLoad0),  32'd0);
        check("reset oClear",  32'(oClear0), 32'd0);
        check("reset oValid",  32'(oValid0), 32'd0);
        check("reset oPart",   32'(oPart0),  32'd0);
        check("reset oSel",    32'(oSel0),   32'd0);

        for (int i = 0; i < 23; i++) begin
            check($sformatf("load table cycle %0d", i), 32'(dut_out(0)), 32'(tbl[i].exp));
            tick(1'b0, tbl[i].v, tbl[i].wl, tbl[i].rdy);
        end

        // No-load frame, then 5 stalled DONE cycles before the handshake.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("oSel cleared by reset", 32'(oSel0), 32'd0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c < 19; c++) begin
            if (c == 1)  check("no-load oClear c1", 32'(oClear0), 32'd1);
            if (c == 2)  check("no-load oClear c2", 32'(oClear0), 32'd0);
            if (c == 8)  check("no-load oPart c8",  32'(oPart0),  32'd0);
            if (c == 9)  check("no-load oPart c9",  32'(oPart0),  32'd1);
            if (c == 16) check("no-load oPart c16", 32'(oPart0),  32'd1);
            if (c == 18) check("no-load oValid c18", 32'(oValid0), 32'd0);
            tick(1'b0, 1'b0, 1'b0, 1'b1);
        end
        vcnt = 0;
        for (int c = 19; c <= 24; c++) begin
            if (oValid0) vcnt++;
            check("stall oSel before handshake", 32'(oSel0), 32'd0);
            tick(1'b0, 1'b0, 1'b0, (c == 24));
        end
        check("stall oValid cycle count", 32'(vcnt), 32'd6);
        check("stall post oValid", 32'(oValid0), 32'd0);
        check("stall post iReady", 32'(iReady0), 32'd1);
        check("stall post oSel",   32'(oSel0),   32'd1);
`ifdef FSU_LINEAR_CTRL_STALL_CNT_EN
        check("stall counter", 32'(oStall0), 32'd5);
`endif

        // Reset during RUN cycle 6.
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) tick((c == 6), 1'b0, 1'b0, 1'b0);
        check("mid-run reset iReady", 32'(iReady0), 32'd1);
        check("mid-run reset oPart",  32'(oPart0),  32'd0);
        check("mid-run reset oSel",   32'(oSel0),   32'd0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("restart oClear", 32'(oClear0), 32'd1);
        for (int c = 0; c < 25; c++) tick(1'b0, 1'b0, 1'b0, 1'b1);

        // iValid held high: exactly one frame per IDLE visit.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        vcnt = 0;
        for (int c = 0; c <= 40; c++) begin
            if (c == 19) check("b2b oValid c19", 32'(oValid0), 32'd1);
            if (c == 20) begin
                check("b2b iReady c20", 32'(iReady0), 32'd1);
                check("b2b oSel c20",   32'(oSel0),   32'd1);
            end
            if (c == 40) begin
                check("b2b iReady c40", 32'(iReady0), 32'd1);
                check("b2b oSel c40",   32'(oSel0),   32'd0);
            end
            if (oValid0) vcnt++;
            tick(1'b0, 1'b1, 1'b0, 1'b1);
        end
        check("b2b oValid cycle count", 32'(vcnt), 32'd2);

        // LAT=0, FOLD=1, CWID=2 instance.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            check("lat0 oValid early", 32'(oValid1), 32'd0);
            check("lat0 oPart",        32'(oPart1),  32'd0);
            tick(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("lat0 oValid c5", 32'(oValid1), 32'd1);
        check("lat0 oPart c5",  32'(oPart1),  32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("lat0 iReady c6", 32'(iReady1), 32'd1);
        check("lat0 oSel c6",   32'(oSel1),   32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++)
            tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
